// File: rtl/rx_trigger_gen.sv
// Receive-side TLP trigger generator: turns committed write-pointer progress into full/last TLP requests.
// Define RX_TRIGGER_TIMEOUT_EN to compile in the idle-timeout partial flush of the current huge page.
module rx_trigger_gen #(
    parameter int AW        = 9,
    parameter int PAGE_LOG2 = 18,
    parameter int TIMEOUT   = 1023
) (
    input  logic          clk_in,
    input  logic          reset_n_clk_in,
    input  logic [AW-1:0] commit_wr_addr,
    output logic          trigger_tlp,
    output logic          send_last_tlp,
    output logic [4:0]    qwords_to_send,
    input  logic          trigger_tlp_ack,
    input  logic          change_huge_page_ack,
    output logic [AW-1:0] issued_addr
);

    localparam logic [AW-1:0]        TLP_QW    = AW'(16);
    localparam logic [PAGE_LOG2-1:0] TLP_QW_PG = PAGE_LOG2'(16);
    localparam logic [PAGE_LOG2:0]   TLP_QW_RM = (PAGE_LOG2 + 1)'(16);
    localparam logic [PAGE_LOG2:0]   PAGE_QW   = {1'b1, {PAGE_LOG2{1'b0}}};

    if (AW < 5 || PAGE_LOG2 < 4 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("rx_trigger_gen: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ_TLP,
        S_REQ_LAST,
        S_GAP
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [AW-1:0]        r_commit_q;
    logic [AW-1:0]        r_issued, w_issued_nxt;
    logic [PAGE_LOG2-1:0] r_page_qw, w_page_qw_nxt;
    logic                 r_trig, w_trig_nxt;
    logic                 r_last, w_last_nxt;
    logic [4:0]           r_qw, w_qw_nxt;

    logic [AW-1:0]        w_pending;
    logic [PAGE_LOG2:0]   w_page_rem;
    logic                 w_full_avail;
    logic                 w_flush;

    // Pointer difference is taken modulo 2^AW, so wrap needs no special case.
    assign w_pending    = r_commit_q - r_issued;
    assign w_page_rem   = PAGE_QW - {1'b0, r_page_qw};
    assign w_full_avail = (w_pending >= TLP_QW);

`ifdef RX_TRIGGER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [15:0] r_idle_cnt;

    // Idle time only accumulates while waiting in IDLE on a stable, non-empty backlog.
    always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
        if (!reset_n_clk_in) begin
            r_idle_cnt <= '0;
        end else if ((commit_wr_addr != r_commit_q) || (r_state != S_IDLE) || (w_pending == '0)) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TIMEOUT_W) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign w_flush = (w_pending != '0) && !w_full_avail && (r_idle_cnt == TIMEOUT_W);
`else
    assign w_flush = 1'b0;
`endif

    always_comb begin
        // NOTE: every next value defaults to its current register, so no branch can infer a latch.
        w_state_nxt   = r_state;
        w_trig_nxt    = r_trig;
        w_last_nxt    = r_last;
        w_qw_nxt      = r_qw;
        w_issued_nxt  = r_issued;
        w_page_qw_nxt = r_page_qw;

        unique case (r_state)
            S_IDLE: begin
                if (w_full_avail && (w_page_rem > TLP_QW_RM)) begin
                    w_state_nxt = S_REQ_TLP;
                    w_trig_nxt  = 1'b1;
                    w_qw_nxt    = 5'd16;
                end else if (w_full_avail && (w_page_rem == TLP_QW_RM)) begin
                    w_state_nxt = S_REQ_LAST;
                    w_last_nxt  = 1'b1;
                    w_qw_nxt    = 5'd16;
                end else if (w_flush) begin
                    w_state_nxt = S_REQ_LAST;
                    w_last_nxt  = 1'b1;
                    w_qw_nxt    = w_pending[4:0];
                end
            end
            S_REQ_TLP: begin
                if (trigger_tlp_ack) begin
                    w_state_nxt   = S_GAP;
                    w_trig_nxt    = 1'b0;
                    w_issued_nxt  = r_issued + TLP_QW;
                    w_page_qw_nxt = r_page_qw + TLP_QW_PG;
                end
            end
            S_REQ_LAST: begin
                // A partial last TLP restarts the page count so the next page begins aligned.
                if (change_huge_page_ack) begin
                    w_state_nxt   = S_GAP;
                    w_last_nxt    = 1'b0;
                    w_issued_nxt  = r_issued + AW'(r_qw);
                    w_page_qw_nxt = '0;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_clk_in) begin
        if (!reset_n_clk_in) begin
            r_state    <= S_IDLE;
            r_commit_q <= '0;
            r_issued   <= '0;
            r_page_qw  <= '0;
            r_trig     <= 1'b0;
            r_last     <= 1'b0;
            r_qw       <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            r_state    <= w_state_nxt;
            r_commit_q <= commit_wr_addr;
            r_issued   <= w_issued_nxt;
            r_page_qw  <= w_page_qw_nxt;
            r_trig     <= w_trig_nxt;
            r_last     <= w_last_nxt;
            r_qw       <= w_qw_nxt;
        end
    end

    assign trigger_tlp    = r_trig;
    assign send_last_tlp  = r_last;
    assign qwords_to_send = r_qw;
    assign issued_addr    = r_issued;

endmodule

// File: tb/tb_rx_trigger_gen.sv
// Self-checking bench for rx_trigger_gen: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a rule-level reference model.
module tb_rx_trigger_gen;

    localparam int AW   = 5;
    localparam int PL   = 6;
    localparam int TO   = 8;
    localparam int MASK = (1 << AW) - 1;
    localparam int PAGE = 1 << PL;

    logic          clk_in;
    logic          reset_n_clk_in;
    logic [AW-1:0] commit_wr_addr;
    logic          trigger_tlp;
    logic          send_last_tlp;
    logic [4:0]    qwords_to_send;
    logic          trigger_tlp_ack;
    logic          change_huge_page_ack;
    logic [AW-1:0] issued_addr;

    int n_cmp = 0;
    int n_bad = 0;

    rx_trigger_gen #(.AW(AW), .PAGE_LOG2(PL), .TIMEOUT(TO)) u_dut (
        .clk_in               (clk_in),
        .reset_n_clk_in       (reset_n_clk_in),
        .commit_wr_addr       (commit_wr_addr),
        .trigger_tlp          (trigger_tlp),
        .send_last_tlp        (send_last_tlp),
        .qwords_to_send       (qwords_to_send),
        .trigger_tlp_ack      (trigger_tlp_ack),
        .change_huge_page_ack (change_huge_page_ack),
        .issued_addr          (issued_addr)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs away from the edge, then sample 1 time unit after it.
    task automatic cyc(input logic [AW-1:0] c, input logic ta, input logic la);
        commit_wr_addr       = c;
        trigger_tlp_ack      = ta;
        change_huge_page_ack = la;
        @(posedge clk_in);
        #1;
    endtask

    // Reference model: request kind 0=none, 1=full TLP, 2=last TLP.
    int m_cq, m_issued, m_page, m_idle, m_req, m_prev, m_cnt;

    task automatic model_reset();
        m_cq = 0; m_issued = 0; m_page = 0; m_idle = 0; m_req = 0; m_prev = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input int c, input bit ta, input bit la);
        int pend, n_req, n_cnt, n_issued, n_page, n_idle;
        bit waiting;
        pend     = (m_cq - m_issued) & MASK;
        // Free to decide only if no request was up in either of the last two cycles (ack + gap).
        waiting  = (m_req == 0) && (m_prev == 0);
        n_req    = m_req;
        n_cnt    = m_cnt;
        n_issued = m_issued;
        n_page   = m_page;
        if (m_req == 1) begin
            if (ta) begin
                n_req = 0; n_issued = (m_issued + 16) & MASK; n_page = m_page + 16;
            end
        end else if (m_req == 2) begin
            if (la) begin
                n_req = 0; n_issued = (m_issued + m_cnt) & MASK; n_page = 0;
            end
        end else if (waiting) begin
            if (pend >= 16 && PAGE - m_page > 16) begin
                n_req = 1; n_cnt = 16;
            end else if (pend >= 16 && PAGE - m_page == 16) begin
                n_req = 2; n_cnt = 16;
            end
`ifdef RX_TRIGGER_TIMEOUT_EN
            else if (pend > 0 && pend < 16 && m_idle == TO) begin
                n_req = 2; n_cnt = pend;
            end
`endif
        end
        if (c != m_cq || !waiting || pend == 0) n_idle = 0;
        else n_idle = (m_idle + 1 > TO) ? TO : m_idle + 1;
        m_prev = m_req; m_req = n_req; m_cnt = n_cnt;
        m_issued = n_issued; m_page = n_page; m_idle = n_idle; m_cq = c;
    endtask

    task automatic reset_dut();
        reset_n_clk_in       = 1'b0;
        commit_wr_addr       = '0;
        trigger_tlp_ack      = 1'b0;
        change_huge_page_ack = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 reset_n_clk_in = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [AW-1:0] commit;
        logic          ta;
        logic          la;
        logic          trig;
        logic          last;
        int            qw;
        int            issued;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int c, input bit ta, input bit la, input bit tr, input bit ls,
                       input int qw, input int iss);
        vec_t v;
        v.commit = AW'(c); v.ta = ta; v.la = la; v.trig = tr; v.last = ls; v.qw = qw; v.issued = iss;
        vecs.push_back(v);
    endtask

    initial begin
        int rc;
        int room;
        int r;
        logic [AW-1:0] c;
        logic ta, la;

        reset_n_clk_in = 1'b0;
        reset_dut();
        check("reset trig", trigger_tlp, 0);
        check("reset last", send_last_tlp, 0);
        check("reset qw", qwords_to_send, 0);
        check("reset issued", issued_addr, 0);

        // Directed table: full TLPs, page fill into a last TLP, wrap, stray and wrong-type acks.
        add(16, 0, 0, 0, 0, 0, 0);   add(16, 0, 0, 1, 0, 16, 0);
        add(16, 0, 0, 1, 0, 16, 0);  add(16, 0, 0, 1, 0, 16, 0);
        add(16, 1, 0, 0, 0, 0, 16);  add(16, 0, 0, 0, 0, 0, 16);
        add(16, 0, 0, 0, 0, 0, 16);  add(16, 0, 0, 0, 0, 0, 16);
        add(0, 0, 0, 0, 0, 0, 16);   add(0, 0, 0, 1, 0, 16, 16);
        add(0, 1, 0, 0, 0, 0, 0);    add(16, 0, 0, 0, 0, 0, 0);
        add(16, 0, 0, 1, 0, 16, 0);  add(16, 1, 0, 0, 0, 0, 16);
        add(0, 0, 0, 0, 0, 0, 16);   add(0, 0, 0, 0, 1, 16, 16);
        add(0, 0, 1, 0, 0, 0, 0);    add(16, 0, 0, 0, 0, 0, 0);
        add(16, 0, 0, 1, 0, 16, 0);  add(16, 1, 0, 0, 0, 0, 16);
        add(16, 1, 1, 0, 0, 0, 16);  add(16, 1, 1, 0, 0, 0, 16);
        add(0, 0, 0, 0, 0, 0, 16);   add(0, 0, 0, 1, 0, 16, 16);
        add(0, 0, 1, 1, 0, 16, 16);  add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);    add(0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].commit, vecs[i].ta, vecs[i].la);
            check($sformatf("vec%0d trig", i), trigger_tlp, vecs[i].trig);
            check($sformatf("vec%0d last", i), send_last_tlp, vecs[i].last);
            check($sformatf("vec%0d issued", i), issued_addr, vecs[i].issued);
            if (vecs[i].trig || vecs[i].last)
                check($sformatf("vec%0d qw", i), qwords_to_send, vecs[i].qw);
        end

        // Partial data: issued=0, page holds 32 qwords at this point.
`ifdef RX_TRIGGER_TIMEOUT_EN
        for (int k = 0; k < 9; k++) begin
            cyc(5, 0, 0);
            check($sformatf("to wait%0d req", k), {trigger_tlp, send_last_tlp}, 0);
        end
        cyc(5, 0, 0);
        check("to flush last", send_last_tlp, 1);
        check("to flush trig", trigger_tlp, 0);
        check("to flush qw", qwords_to_send, 5);
        cyc(5, 0, 1);
        check("to ack issued", issued_addr, 5);
        check("to ack last", send_last_tlp, 0);
        cyc(21, 0, 0);
        cyc(21, 0, 0);
        check("fresh page trig", trigger_tlp, 1);
        check("fresh page last", send_last_tlp, 0);
        cyc(21, 1, 0);
        check("fresh page issued", issued_addr, 21);
        cyc(5, 0, 0);
        cyc(5, 0, 0);
        check("wrap trig", trigger_tlp, 1);
        check("wrap last", send_last_tlp, 0);
        check("wrap qw", qwords_to_send, 16);
        cyc(5, 1, 0);
        check("wrap issued", issued_addr, 5);
`else
        for (int k = 0; k < 20; k++) begin
            cyc(5, 0, 0);
            check($sformatf("partial hold%0d req", k), {trigger_tlp, send_last_tlp}, 0);
        end
        cyc(21, 0, 0);
        cyc(21, 0, 0);
        check("accum trig", trigger_tlp, 1);
        check("accum qw", qwords_to_send, 16);
        cyc(21, 1, 0);
        check("accum issued", issued_addr, 16);
        for (int k = 0; k < 6; k++) begin
            cyc(21, 0, 0);
            check($sformatf("remainder%0d req", k), {trigger_tlp, send_last_tlp}, 0);
        end
`endif

        // Reset asserted while a request is held.
        reset_dut();
        cyc(16, 0, 0);
        cyc(16, 0, 0);
        cyc(16, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("pre-reset trig", trigger_tlp, 1);
        check("pre-reset issued", issued_addr, 16);
        #2 reset_n_clk_in = 1'b0;
        #1;
        check("async rst trig", trigger_tlp, 0);
        check("async rst qw", qwords_to_send, 0);
        check("async rst issued", issued_addr, 0);
        @(posedge clk_in);
        #1 reset_n_clk_in = 1'b1;
        cyc(16, 0, 0);
        check("post-rst idle", trigger_tlp, 0);
        cyc(16, 0, 0);
        check("post-rst re-request", trigger_tlp, 1);
        check("post-rst qw", qwords_to_send, 16);

        // Randomized traffic against the reference model.
        reset_dut();
        rc = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) begin
                room = MASK - ((rc - m_issued) & MASK);
                if (room > 0) rc = (rc + int'($urandom_range((room > 20) ? 20 : room, 1))) & MASK;
            end
            r  = int'($urandom_range(9));
            ta = (r < 3) || (r == 5);
            la = (r == 3) || (r == 4) || (r == 5);
            c  = AW'(rc);
            model_edge(rc, ta, la);
            cyc(c, ta, la);
            check("rnd trig", trigger_tlp, (m_req == 1));
            check("rnd last", send_last_tlp, (m_req == 2));
            check("rnd issued", issued_addr, m_issued);
            if (m_req != 0) check("rnd qw", qwords_to_send, m_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
